// File: rtl/zhegalkin_pkg.sv
// Shared definitions for the Zhegalkin (ANF) transform/evaluate family:
// FSM states, default variable count and the monomial-subset test.
package zhegalkin_pkg;

  localparam int unsigned N_DEFAULT = 3;
  localparam int unsigned SUBSET_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Monomial m contributes to f(x) exactly when every variable of m is set in x.
  function automatic logic subset(input logic [SUBSET_W-1:0] m, input logic [SUBSET_W-1:0] x);
    return ((m & ~x) == {SUBSET_W{1'b0}});
  endfunction

endpackage

// File: rtl/zhegalkin_eval.sv
// Serial Zhegalkin polynomial evaluator: for each accepted x, XORs the
// coefficients of all monomials contained in x, one monomial per enabled cycle.
module zhegalkin_eval
  import zhegalkin_pkg::*;
#(
  parameter  int unsigned N = N_DEFAULT,
  localparam int unsigned W = 2**N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         coef_load,
  input  logic [W-1:0] coef,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [N-1:0] x,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         y,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [W-1:0] coef_q, coef_d;
  logic         acc_q, acc_d;
  logic [N-1:0] m_q, m_d;
  logic [N-1:0] x_q, x_d;
  logic         y_valid_q, y_valid_d;
  logic         y_q, y_d;
  logic         busy_q, busy_d;

  // Gated by reset so nothing is offered while the block is held in reset.
  assign x_ready = reset & (state_q == ST_IDLE) & enable & ~coef_load;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    m_d     = m_q;
    x_d     = x_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && coef_load) begin
          coef_d = coef;
        end else if (enable && x_valid) begin
          x_d     = x;
          acc_d   = 1'b0;
          m_d     = '0;
          state_d = ST_EVAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (enable) begin
          if (subset(SUBSET_W'(m_q), SUBSET_W'(x_q))) begin
            acc_d = acc_q ^ coef_q[m_q];
          end else begin
            acc_d = acc_q;
          end
          if (m_q == N'(W - 1)) begin
            state_d = ST_DONE;
          end else begin
            m_d = m_q + N'(1);
          end
        end else begin
          state_d = ST_EVAL;
        end
      end
      // The result handshake is honoured even while enable is low.
      ST_DONE: begin
        if (y_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    y_valid_d = (state_d == ST_DONE);
    y_d       = (state_d == ST_DONE) ? acc_d : 1'b0;
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      coef_q    <= '0;
      acc_q     <= 1'b0;
      m_q       <= '0;
      x_q       <= '0;
      y_valid_q <= 1'b0;
      y_q       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      coef_q    <= coef_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      x_q       <= x_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y       = y_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_zhegalkin_eval.sv
// Self-checking bench for zhegalkin_eval (N=3): directed and random queries
// compared against an ANF sum-of-products reference model.
module tb_zhegalkin_eval;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       coef_load = 1'b0;
  logic [7:0] coef = 8'h00;
  logic       x_valid = 1'b0;
  logic       x_ready;
  logic [2:0] x = 3'd0;
  logic       y_valid;
  logic       y_ready = 1'b0;
  logic       y;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] coef_model = 8'h00;

  zhegalkin_eval #(.N(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .coef_load(coef_load),
    .coef(coef), .x_valid(x_valid), .x_ready(x_ready), .x(x),
    .y_valid(y_valid), .y_ready(y_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  // f(x) = XOR over m of c[m] * prod_{i in m} x_i
  function automatic logic ref_f(input logic [7:0] c, input logic [2:0] xv);
    logic r, term;
    r = 1'b0;
    for (int m = 0; m < 8; m++) begin
      term = c[m];
      for (int i = 0; i < 3; i++) if (m[i]) term = term & xv[i];
      r = r ^ term;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    coef_load = 1'b1; coef = v;
    #1 chk("x_ready_during_load", x_ready, 0);
    @(negedge clk);
    coef_load = 1'b0;
    coef_model = v;
  endtask

  task automatic query(input logic [2:0] xv, input int stall_at, input int stall_len,
                       input int load_at, input int hold, input int exp_lat);
    logic exp_y;
    int cnt;
    bit got;
    exp_y = ref_f(coef_model, xv);
    cnt = 0;
    while (!x_ready && cnt < 20) begin @(negedge clk); cnt++; end
    chk("x_ready_idle", x_ready, 1);
    x = xv; x_valid = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0; x = ~xv;
    cnt = 0; got = 1'b0;
    while (!got && cnt < 40) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (cnt == stall_at) enable = 1'b0;
      if (cnt == stall_at + stall_len) enable = 1'b1;
      if (cnt == load_at) begin coef_load = 1'b1; coef = 8'hFF; end
      else coef_load = 1'b0;
      if (y_valid) got = 1'b1;
    end
    enable = 1'b1; coef_load = 1'b0;
    if (!got) chk("y_valid_timeout", 0, 1);
    chk("latency", cnt, exp_lat);
    chk("y", y, exp_y);
    chk("busy_done", busy, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_y_valid", y_valid, 1);
      chk("hold_y", y, exp_y);
      chk("hold_x_ready", x_ready, 0);
      chk("hold_busy", busy, 1);
    end
    y_ready = 1'b1;
    @(posedge clk);
    #1 y_ready = 1'b0;
    @(negedge clk);
    chk("y_valid_after_hs", y_valid, 0);
    chk("busy_after_hs", busy, 0);
    chk("x_ready_after_hs", x_ready, 1);
  endtask

  initial begin
    #2;
    chk("rst_x_ready", x_ready, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    enable = 1'b0;
    #1 chk("x_ready_enable_low", x_ready, 0);
    enable = 1'b1;

    // Constant polynomial
    load(8'h01);
    for (int i = 0; i < 8; i++) query(3'(i), -1, 0, -1, 0, 8);

    // Parity x0^x1^x2
    load(8'h16);
    for (int i = 0; i < 8; i++) query(3'(i), -1, 0, -1, 0, 8);

    // 1 ^ x0x1
    load(8'h09);
    query(3'd3, -1, 0, -1, 0, 8);
    query(3'd1, -1, 0, -1, 0, 8);
    query(3'd7, -1, 0, -1, 0, 8);

    // Enable stall in EVAL, then backpressure in DONE
    query(3'd2, 2, 3, -1, 5, 11);

    // Load attempt mid-EVAL is ignored
    load(8'h16);
    query(3'd3, -1, 0, 3, 0, 8);
    query(3'd1, -1, 0, -1, 0, 8);

    // Reset in the middle of EVAL
    while (!x_ready) @(negedge clk);
    x = 3'd7; x_valid = 1'b1;
    @(posedge clk);
    #1 x_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy_mid_eval", busy, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_y_valid", y_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_x_ready", x_ready, 0);
    @(negedge clk); reset = 1'b1;
    coef_model = 8'h00;
    @(negedge clk);
    query(3'd5, -1, 0, -1, 0, 8);

    // Random coefficients, points, stalls and backpressure
    for (int r = 0; r < 24; r++) begin
      int sa, sl;
      if (r % 4 == 0) load(8'($urandom));
      sa = int'($urandom_range(1, 6));
      sl = int'($urandom_range(0, 3));
      query(3'($urandom), sa, sl, -1, int'($urandom_range(0, 3)), 8 + sl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
